// File: rtl/ckpt_pkg.sv
// rtl/ckpt_pkg.sv - shared types and sizes for the free-list branch checkpoint controller
package ckpt_pkg;

  localparam int NUM_CKPT = 4;
  localparam int TAG_W    = 2;
  localparam int HEAD_W   = 5;

  typedef logic [TAG_W-1:0]    ckpt_tag_t;
  typedef logic [NUM_CKPT-1:0] ckpt_mask_t;
  typedef logic [HEAD_W-1:0]   ckpt_head_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } ckpt_state_e;

  function automatic ckpt_mask_t tag_onehot(input ckpt_tag_t tag);
    return ckpt_mask_t'(1) << tag;
  endfunction

endpackage

// File: rtl/fl_ckpt_ctrl_if.sv
// rtl/fl_ckpt_ctrl_if.sv - dispatch/resolve/recovery bundle between pipeline and checkpoint controller
interface fl_ckpt_ctrl_if;
  import ckpt_pkg::*;

  logic       br_dispatch_en_i;
  ckpt_head_t fl_head_i;
  logic       ckpt_avail_o;
  ckpt_tag_t  ckpt_tag_o;
  logic       br_resolve_en_i;
  ckpt_tag_t  br_resolve_tag_i;
  logic       br_mispredict_i;
  logic       flush_i;
  logic       fl_recover_en_o;
  ckpt_head_t fl_recover_head_o;
  ckpt_mask_t squash_mask_o;
  ckpt_mask_t valid_mask_o;

  modport master (
    output br_dispatch_en_i, fl_head_i, br_resolve_en_i, br_resolve_tag_i,
           br_mispredict_i, flush_i,
    input  ckpt_avail_o, ckpt_tag_o, fl_recover_en_o, fl_recover_head_o,
           squash_mask_o, valid_mask_o
  );

  modport slave (
    input  br_dispatch_en_i, fl_head_i, br_resolve_en_i, br_resolve_tag_i,
           br_mispredict_i, flush_i,
    output ckpt_avail_o, ckpt_tag_o, fl_recover_en_o, fl_recover_head_o,
           squash_mask_o, valid_mask_o
  );

endinterface

// File: rtl/ckpt_pri_enc.sv
// rtl/ckpt_pri_enc.sv - lowest-zero finder over an occupancy mask
module ckpt_pri_enc #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        idx      = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// rtl/fl_ckpt_ctrl.sv - branch checkpoint controller sequencing free-list head recovery
module fl_ckpt_ctrl
  import ckpt_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  fl_ckpt_ctrl_if.slave bus
);

  ckpt_mask_t  valid_q;
  ckpt_mask_t  dep_q  [NUM_CKPT];
  ckpt_head_t  head_q [NUM_CKPT];
  ckpt_state_e state_q;
  logic        rec_en_q;
  ckpt_head_t  rec_head_q;
  ckpt_mask_t  squash_q;

  ckpt_tag_t   free_idx;
  logic        any_free;
  logic        avail;
  logic        res_hit;
  logic        mis;
  logic        cor;
  logic        alloc;
  ckpt_mask_t  squash_set;
  ckpt_mask_t  clr_mask;

  ckpt_pri_enc #(
    .W  (NUM_CKPT),
    .IW (TAG_W)
  ) u_pri_enc (
    .mask     (valid_q),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign avail                 = any_free && (state_q == IDLE);
  assign bus.ckpt_avail_o      = avail;
  assign bus.ckpt_tag_o        = free_idx;
  assign bus.valid_mask_o      = valid_q;
  assign bus.fl_recover_en_o   = rec_en_q;
  assign bus.fl_recover_head_o = rec_head_q;
  assign bus.squash_mask_o     = squash_q;

  // A slot younger than the mispredicting branch is exactly one whose dep still names it.
  always_comb begin
    res_hit    = bus.br_resolve_en_i && valid_q[bus.br_resolve_tag_i];
    mis        = res_hit && bus.br_mispredict_i;
    cor        = res_hit && !bus.br_mispredict_i;
    squash_set = tag_onehot(bus.br_resolve_tag_i);
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (valid_q[i] && dep_q[i][bus.br_resolve_tag_i]) begin
        squash_set[i] = 1'b1;
      end
    end
    clr_mask = '0;
    if (mis) begin
      clr_mask = squash_set;
    end else if (cor) begin
      clr_mask = tag_onehot(bus.br_resolve_tag_i);
    end
    alloc = bus.br_dispatch_en_i && avail && !mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      state_q    <= IDLE;
      rec_en_q   <= 1'b0;
      rec_head_q <= '0;
      squash_q   <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        dep_q[i]  <= '0;
        head_q[i] <= '0;
      end
    end else if (bus.flush_i) begin
      valid_q  <= '0;
      state_q  <= IDLE;
      rec_en_q <= 1'b0;
      squash_q <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        dep_q[i] <= '0;
      end
    end else begin
      valid_q <= (valid_q & ~clr_mask) | (alloc ? tag_onehot(free_idx) : '0);
      for (int i = 0; i < NUM_CKPT; i++) begin
        dep_q[i] <= dep_q[i] & ~clr_mask;
      end
      // The granted slot was free under the registered mask, so it never collides with clr_mask.
      if (alloc) begin
        dep_q[free_idx]  <= valid_q & ~clr_mask;
        head_q[free_idx] <= bus.fl_head_i;
      end
      state_q  <= mis ? RECOVER : IDLE;
      rec_en_q <= mis;
      squash_q <= mis ? clr_mask : '0;
      if (mis) begin
        rec_head_q <= head_q[bus.br_resolve_tag_i];
      end
    end
  end

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// tb/tb_fl_ckpt_ctrl.sv - randomized self-checking bench against an age-ordered branch model
module tb_fl_ckpt_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fl_ckpt_ctrl_if bus ();

  fl_ckpt_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight branches, oldest first; squashing a branch removes it and everything behind it.
  int         q_tag  [$];
  logic [4:0] q_head [$];
  bit         m_rec;
  bit         e_en;
  logic [4:0] e_head;
  logic [3:0] e_sq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] m_mask();
    logic [3:0] v;
    v = '0;
    foreach (q_tag[i]) v[q_tag[i]] = 1'b1;
    return v;
  endfunction

  function automatic int m_free();
    logic [3:0] v;
    v = m_mask();
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q_tag.delete();
    q_head.delete();
    m_rec  = 0;
    e_en   = 0;
    e_sq   = '0;
    e_head = '0;
  endtask

  task automatic model_step(input bit d, input logic [4:0] h, input bit r,
                            input logic [1:0] t, input bit m, input bit f);
    int pos;
    int g;
    bit avail;
    logic [3:0] sq;
    if (f) begin
      q_tag.delete();
      q_head.delete();
      m_rec = 0;
      e_en  = 0;
      e_sq  = '0;
      return;
    end
    pos = -1;
    for (int i = 0; i < q_tag.size(); i++) if (q_tag[i] == int'(t)) pos = i;
    g     = m_free();
    avail = (g >= 0) && !m_rec;
    if (r && pos >= 0 && m) begin
      e_head = q_head[pos];
      sq = '0;
      for (int i = pos; i < q_tag.size(); i++) sq[q_tag[i]] = 1'b1;
      while (q_tag.size() > pos) begin
        void'(q_tag.pop_back());
        void'(q_head.pop_back());
      end
      e_en  = 1;
      e_sq  = sq;
      m_rec = 1;
    end else begin
      if (r && pos >= 0) begin
        q_tag.delete(pos);
        q_head.delete(pos);
      end
      if (d && avail) begin
        q_tag.push_back(g);
        q_head.push_back(h);
      end
      e_en  = 0;
      e_sq  = '0;
      m_rec = 0;
    end
  endtask

  task automatic check_model();
    bit want_avail;
    want_avail = (m_free() >= 0) && !m_rec;
    check_eq("avail", 32'(bus.ckpt_avail_o), 32'(want_avail));
    if (want_avail) check_eq("tag", 32'(bus.ckpt_tag_o), 32'(m_free()));
    check_eq("valid_mask", 32'(bus.valid_mask_o), 32'(m_mask()));
    check_eq("rec_en", 32'(bus.fl_recover_en_o), 32'(e_en));
    check_eq("squash", 32'(bus.squash_mask_o), 32'(e_sq));
    if (e_en) check_eq("rec_head", 32'(bus.fl_recover_head_o), 32'(e_head));
  endtask

  // Called at a negedge: drive, clock once, land on the next negedge and check.
  task automatic cycle(input bit d, input logic [4:0] h, input bit r,
                       input logic [1:0] t, input bit m, input bit f);
    bus.br_dispatch_en_i = d;
    bus.fl_head_i        = h;
    bus.br_resolve_en_i  = r;
    bus.br_resolve_tag_i = t;
    bus.br_mispredict_i  = m;
    bus.flush_i          = f;
    model_step(d, h, r, t, m, f);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    cycle(0, 5'd0, 0, 2'd0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.br_dispatch_en_i = 0;
    bus.fl_head_i        = '0;
    bus.br_resolve_en_i  = 0;
    bus.br_resolve_tag_i = '0;
    bus.br_mispredict_i  = 0;
    bus.flush_i          = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_model();
    check_eq("reset_head", 32'(bus.fl_recover_head_o), 32'd0);
    check_eq("reset_tag", 32'(bus.ckpt_tag_o), 32'd0);
    check_eq("reset_avail", 32'(bus.ckpt_avail_o), 32'd1);

    cycle(1, 5'd3, 0, 2'd0, 0, 0);
    cycle(1, 5'd7, 0, 2'd0, 0, 0);
    cycle(1, 5'd9, 0, 2'd0, 0, 0);
    cycle(1, 5'd12, 0, 2'd0, 0, 0);
    check_eq("full_avail", 32'(bus.ckpt_avail_o), 32'd0);
    cycle(1, 5'd20, 0, 2'd0, 0, 0);
    check_eq("full_mask", 32'(bus.valid_mask_o), 32'hF);

    cycle(0, 5'd0, 1, 2'd1, 1, 0);
    check_eq("mp1_en", 32'(bus.fl_recover_en_o), 32'd1);
    check_eq("mp1_head", 32'(bus.fl_recover_head_o), 32'd7);
    check_eq("mp1_sq", 32'(bus.squash_mask_o), 32'hE);
    check_eq("mp1_valid", 32'(bus.valid_mask_o), 32'h1);
    idle();
    check_eq("rec_end", 32'(bus.fl_recover_en_o), 32'd0);

    check_eq("pre_cor_tag", 32'(bus.ckpt_tag_o), 32'd1);
    cycle(1, 5'd5, 1, 2'd0, 0, 0);
    check_eq("cor_valid", 32'(bus.valid_mask_o), 32'h2);
    cycle(0, 5'd0, 1, 2'd1, 1, 0);
    check_eq("self_sq", 32'(bus.squash_mask_o), 32'h2);
    check_eq("self_head", 32'(bus.fl_recover_head_o), 32'd5);
    idle();

    cycle(1, 5'd3, 0, 2'd0, 0, 0);
    cycle(1, 5'd4, 0, 2'd0, 0, 0);
    cycle(1, 5'd6, 0, 2'd0, 0, 0);
    cycle(1, 5'd8, 1, 2'd2, 1, 0);
    check_eq("mp2_head", 32'(bus.fl_recover_head_o), 32'd6);
    check_eq("mp2_valid", 32'(bus.valid_mask_o), 32'h3);
    cycle(0, 5'd0, 1, 2'd0, 1, 0);
    check_eq("mp0_en", 32'(bus.fl_recover_en_o), 32'd1);
    check_eq("mp0_head", 32'(bus.fl_recover_head_o), 32'd3);
    check_eq("mp0_sq", 32'(bus.squash_mask_o), 32'h3);
    idle();

    cycle(1, 5'd11, 0, 2'd0, 0, 0);
    cycle(0, 5'd0, 1, 2'd3, 1, 0);
    check_eq("inv_en", 32'(bus.fl_recover_en_o), 32'd0);
    check_eq("inv_valid", 32'(bus.valid_mask_o), 32'h1);

    cycle(1, 5'd10, 0, 2'd0, 0, 0);
    cycle(0, 5'd0, 1, 2'd1, 1, 0);
    cycle(0, 5'd0, 1, 2'd0, 1, 1);
    check_eq("flush_en", 32'(bus.fl_recover_en_o), 32'd0);
    check_eq("flush_valid", 32'(bus.valid_mask_o), 32'h0);
    idle();

    cycle(1, 5'd17, 0, 2'd0, 0, 0);
    cycle(0, 5'd0, 1, 2'd0, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check_eq("rst_mid_head", 32'(bus.fl_recover_head_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    for (int n = 0; n < 2000; n++) begin
      cycle(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fl_ckpt_ctrl.md
# fl_ckpt_ctrl

Branch-checkpoint controller for the physical-register free list. It snapshots the free-list head pointer on every dispatched branch and tracks branch age through per-slot dependency masks. On a mispredict it sequences the free list's single-cycle head recovery and reports which checkpoint tags are squashed. It sits between the decoder/dispatch stage, the branch-resolution path and the free list's `recover_en_i` / `recover_head_i` inputs.

## Interface
- `NUM_CKPT`, 4: number of checkpoint slots (in-flight branches).
- `TAG_W`, 2: checkpoint tag width, equal to log2(`NUM_CKPT`).
- `HEAD_W`, 5: free-list head pointer width.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `br_dispatch_en_i` input 1: a branch dispatches this cycle and requests a checkpoint.
- `fl_head_i` input `HEAD_W`: the free-list head value to snapshot in the dispatch cycle.
- `ckpt_avail_o` output 1: a slot is free and dispatch is accepted. The decoder stalls branches while this is 0.
- `ckpt_tag_o` output `TAG_W`: the tag granted to the dispatching branch (lowest-index free slot).
- `br_resolve_en_i` input 1: a branch resolves this cycle.
- `br_resolve_tag_i` input `TAG_W`: tag of the resolving branch.
- `br_mispredict_i` input 1: qualifies the resolve as a mispredict.
- `flush_i` input 1: full pipeline flush (exception or retire-time recovery).
- `fl_recover_en_o` output 1: one-cycle recovery pulse to the free list.
- `fl_recover_head_o` output `HEAD_W`: head value to restore.
- `squash_mask_o` output `NUM_CKPT`: one-cycle pulse of squashed tags, broadcast to the RS/ROB.
- `valid_mask_o` output `NUM_CKPT`: currently allocated slots.

## Operation
- Per-slot state:
  - `valid`
  - `head[HEAD_W]`
  - `dep[NUM_CKPT]`: the set of older branches still in flight.
- Allocate: when `br_dispatch_en_i && ckpt_avail_o`:
  - Slot `ckpt_tag_o` takes valid=1 and head=`fl_head_i`.
  - Its dep is set to the current valid mask, minus any tag that is correctly resolving in the same cycle.
- `br_dispatch_en_i` while `ckpt_avail_o`=0 is ignored; the decoder is responsible for stalling.
- Correct resolve of tag t (t valid):
  - Clear valid[t].
  - Clear bit t in every slot's dep.
- Mispredict of tag t (t valid):
  - Squash set S = {t} ∪ {i : valid[i] && dep[i][t]}.
  - Clear valid for every slot in S and clear the S bits in every dep.
  - Latch head[t] into `fl_recover_head_o`.
  - Enter RECOVER.
- A resolve naming an invalid tag is ignored entirely: no state change and no pulse.
- FSM states:
  - IDLE → RECOVER on a valid mispredict.
  - RECOVER → IDLE after exactly 1 cycle, unless another valid mispredict arrives in RECOVER. That mispredict is necessarily older; it restarts RECOVER with its own head and S.
- In RECOVER, `ckpt_avail_o`=0 and dispatch is ignored. Correct resolves are still processed.
- Simultaneous events:
  - Mispredict plus dispatch in the same cycle: the mispredict wins and the dispatch is dropped (that branch is younger).
  - Correct resolve plus dispatch: both are processed. A slot freed this cycle is not grantable until the next cycle.
- `flush_i`, at highest priority:
  - All valid bits clear and all deps clear.
  - FSM goes to IDLE.
  - `fl_recover_en_o` and `squash_mask_o` are forced to 0 in the following cycle. The free list is restored by the flush path, not by this block.

## Timing
- Reset values:
  - valid/dep/head all 0.
  - FSM = IDLE.
  - `fl_recover_en_o`=0, `fl_recover_head_o`=0, `squash_mask_o`=0, `valid_mask_o`=0.
  - `ckpt_avail_o`=1, `ckpt_tag_o`=0.
- `ckpt_avail_o` and `ckpt_tag_o` are combinational from registered valid and FSM state only. There is no input-to-output path.
- `fl_recover_en_o`, `fl_recover_head_o` and `squash_mask_o` are registered. They are valid in the cycle after the mispredict and last 1 cycle.
- The free list applies the recovery on the edge that ends that cycle.
- An allocation is visible in `valid_mask_o` the cycle after dispatch.
- Asserting `rst_n` low mid-recovery clears everything immediately. No pulse completes.

## Structure
- Shared package `ckpt_pkg` holds:
  - `NUM_CKPT`, `TAG_W`
  - `ckpt_tag_t`, `ckpt_mask_t`
  - `ckpt_state_e` {IDLE, RECOVER}
- Sub-module `ckpt_pri_enc` is a parameterised lowest-zero finder over the valid mask. It outputs the index and an any-free flag, and is reused for the ROB tag allocation.

## Test plan
- Reset, then dispatch 4 branches with `fl_head_i`=3,7,9,12 → tags 0,1,2,3; `ckpt_avail_o`=0 after the 4th; a 5th dispatch is ignored.
- From the 4-deep state, mispredict tag 1 → next cycle `fl_recover_en_o`=1, `fl_recover_head_o`=7, `squash_mask_o`=4'b1110; `valid_mask_o`=4'b0001 afterward.
- Correct-resolve tag 0 while dispatching → new branch gets tag 1, not 0. A later mispredict of the new branch squashes only itself (dep excludes tag 0).
- Mispredict tag 2 with a simultaneous dispatch → no allocation. In RECOVER, mispredict tag 0 (head 3) → a second pulse with head 3 and mask including 0.
- Resolve of invalid tag 3 with mispredict → no pulse, state unchanged.
- `flush_i` during RECOVER, and `rst_n` low mid-pulse → all masks 0, IDLE, no further `fl_recover_en_o`.
